// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round sizes, message-schedule state encoding
// and the small-sigma rotate/shift amounts, also used by the compression core.
package sha256_pkg;

    localparam int SHA256_WORD_W    = 32;
    localparam int SHA256_MSG_WORDS = 16;
    localparam int SHA256_ROUNDS    = 64;

    typedef enum logic [1:0] {
        SCHED_IDLE   = 2'd0,
        SCHED_LOAD   = 2'd1,
        SCHED_EXPAND = 2'd2
    } sched_state_t;

    localparam int SIG0_ROT_A = 7;
    localparam int SIG0_ROT_B = 18;
    localparam int SIG0_SHR   = 3;
    localparam int SIG1_ROT_A = 17;
    localparam int SIG1_ROT_B = 19;
    localparam int SIG1_SHR   = 10;

    function automatic logic [SHA256_WORD_W-1:0] rotr(input logic [SHA256_WORD_W-1:0] x,
                                                      input int n);
        return (x >> n) | (x << (SHA256_WORD_W - n));
    endfunction

endpackage

// File: rtl/sha256_sigma_small.sv
// SHA-256 small sigma: sel=0 gives sigma0, sel=1 gives sigma1. Purely combinational.
module sha256_sigma_small
    import sha256_pkg::*;
(
    input  logic                     sel,
    input  logic [SHA256_WORD_W-1:0] x,
    output logic [SHA256_WORD_W-1:0] y
);

    always_comb begin
        if (sel) begin
            y = rotr(x, SIG1_ROT_A) ^ rotr(x, SIG1_ROT_B) ^ (x >> SIG1_SHR);
        end else begin
            y = rotr(x, SIG0_ROT_A) ^ rotr(x, SIG0_ROT_B) ^ (x >> SIG0_SHR);
        end
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: passes M0..M15 through, then expands W16..W63 from a
// 16-word sliding window. Define SHA256_SCHED_OUTREG_EN to register the outputs.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [SHA256_WORD_W-1:0] in_word,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [SHA256_WORD_W-1:0] out_word,
    output logic [5:0]               out_t,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output sched_state_t             dbg_state
);

    // Handshake: a word moves only in a cycle where valid and ready are both 1;
    // valid never waits on ready, and a stalled word holds steady until taken.

    sched_state_t             state, state_n;
    logic [5:0]               t;
    logic [SHA256_WORD_W-1:0] win [SHA256_MSG_WORDS];
    logic [SHA256_WORD_W-1:0] s0, s1, expand_word, push_word;
    logic                     push, last_out, done_q;

    // win[0] is W[t-16], win[15] is W[t-1]
    sha256_sigma_small u_sig0 (.sel(1'b0), .x(win[1]),  .y(s0));
    sha256_sigma_small u_sig1 (.sel(1'b1), .x(win[14]), .y(s1));
    assign expand_word = s1 + win[9] + s0 + win[0];

`ifdef SHA256_SCHED_OUTREG_EN
    logic                     ov_q;
    logic [SHA256_WORD_W-1:0] ow_q;
    logic [5:0]               ot_q;
    logic                     slot_free, accept;

    assign accept    = ov_q && out_ready;
    assign slot_free = !ov_q || out_ready;

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        push      = 1'b0;
        push_word = in_word;
        last_out  = 1'b0;
        case (state)
            SCHED_IDLE: if (start) state_n = SCHED_LOAD;
            SCHED_LOAD: begin
                in_ready = slot_free;
                push     = in_valid && slot_free;
                if (push && t == 6'(SHA256_MSG_WORDS - 1)) state_n = SCHED_EXPAND;
            end
            SCHED_EXPAND: begin
                // t wraps to 0 once W63 has entered the output register
                push      = (t != 6'd0) && slot_free;
                push_word = expand_word;
                if (accept && ot_q == 6'(SHA256_ROUNDS - 1)) begin
                    state_n  = SCHED_IDLE;
                    last_out = 1'b1;
                end
            end
            default: state_n = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
            ow_q <= '0;
            ot_q <= '0;
        end else if (push) begin
            ov_q <= 1'b1;
            ow_q <= push_word;
            ot_q <= t;
        end else if (accept) begin
            ov_q <= 1'b0;
        end
    end

    assign out_valid = ov_q;
    assign out_word  = ow_q;
    assign out_t     = ot_q;
`else
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_word  = '0;
        push      = 1'b0;
        push_word = in_word;
        last_out  = 1'b0;
        case (state)
            SCHED_IDLE: if (start) state_n = SCHED_LOAD;
            SCHED_LOAD: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_word  = in_word;
                push      = in_valid && out_ready;
                if (push && t == 6'(SHA256_MSG_WORDS - 1)) state_n = SCHED_EXPAND;
            end
            SCHED_EXPAND: begin
                out_valid = 1'b1;
                out_word  = expand_word;
                push_word = expand_word;
                push      = out_ready;
                if (push && t == 6'(SHA256_ROUNDS - 1)) begin
                    state_n  = SCHED_IDLE;
                    last_out = 1'b1;
                end
            end
            default: state_n = SCHED_IDLE;
        endcase
    end

    assign out_t = t;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SCHED_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_out;
            if (state == SCHED_IDLE && start) t <= '0;
            else if (push)                    t <= t + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SHA256_MSG_WORDS; i++) win[i] <= '0;
        end else if (push) begin
            for (int i = 0; i < SHA256_MSG_WORDS - 1; i++) win[i] <= win[i+1];
            win[SHA256_MSG_WORDS-1] <= push_word;
        end
    end

    assign busy      = (state != SCHED_IDLE);
    assign done      = done_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: "abc" block, stalls, ignored controls,
// mid-block reset and back-to-back blocks checked against a software schedule.
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [31:0] in_word, out_word;
    logic [5:0]  out_t;
    sched_state_t dbg_state;

    int checks = 0;
    int passed = 0;
    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] exp_q [$];

`ifdef SHA256_SCHED_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    sha256_msg_sched dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .out_valid(out_valid), .out_word(out_word), .out_t(out_t),
        .out_ready(out_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] sg0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sg1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_expected();
        for (int i = 0; i < 64; i++) begin
            if (i < 16) exp_w[i] = msg[i];
            else exp_w[i] = sg1(exp_w[i-2]) + exp_w[i-7] + sg0(exp_w[i-15]) + exp_w[i-16];
        end
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(exp_w[i]);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_expected();
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        build_expected();
    endtask

    // From posedge+1 in IDLE: pulse start, return at posedge+1 in LOAD.
    task automatic begin_block();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    // Runs one block starting at posedge+1 in LOAD. stall toggles out_ready,
    // inject drives start at t=5 and garbage in_valid in EXPAND, abort_at>=0
    // resets the DUT when that many words have been transferred.
    task automatic run_block(input bit stall, input bit inject, input int abort_at,
                             input bit start_in_done, input bit is_abc);
        int t_exp = 0, in_idx = 0, cyc = 0;
        int first_in = -1, first_ov = -1, last_x = -1;
        bit stalled_prev = 0;
        logic [31:0] held_w = '0;
        logic [5:0]  held_t = '0;
        logic [31:0] w;
        while (t_exp < 64 && cyc < 400) begin
            if (abort_at >= 0 && t_exp == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_out_word", out_word, 0);
                check("rst_out_t", out_t, 0);
                @(posedge clk); #1;
                rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check("abort_no_done", done, 0);
                    check("abort_idle", dbg_state, SCHED_IDLE);
                end
                return;
            end
            out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            start     = inject && (t_exp == 5);
            if (in_idx < 16) begin
                in_valid = 1'b1; in_word = msg[in_idx];
            end else begin
                in_valid = inject; in_word = inject ? $urandom : 32'h0;
            end
            #1;
            if (inject && in_idx == 16) check("in_ready_expand", in_ready, 0);
            if (stalled_prev && out_valid) begin
                check("stall_hold_word", out_word, held_w);
                check("stall_hold_t", out_t, held_t);
            end
            if (in_valid && in_ready && in_idx < 16) begin
                if (first_in < 0) first_in = cyc;
                in_idx++;
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                w = exp_q.pop_front();
                check($sformatf("w%0d", t_exp), out_word, w);
                check("out_t", out_t, t_exp);
                if (is_abc && t_exp == 16) check("abc_w16", out_word, 32'h61626380);
                if (is_abc && t_exp == 17) check("abc_w17", out_word, 32'h000F0000);
                if (is_abc && t_exp == 18) check("abc_w18", out_word, 32'h7DA86405);
                if (t_exp == 63) last_x = cyc;
                t_exp++;
            end
            stalled_prev = out_valid && !out_ready;
            held_w = out_word;
            held_t = out_t;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        check("words_transferred", t_exp, 64);
        check("done_pulse", done, 1);
        check("idle_at_done", busy, 0);
        if (!stall && !inject) begin
            check("first_out_latency", first_ov - first_in, LAT);
            check("block_cycles", last_x - first_in + 1, 64 + LAT);
        end
        if (start_in_done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("restart_busy", busy, 1);
        end else begin
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_word", out_word, 0);
        check("reset_out_t", out_t, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 0);
        check("idle_state", dbg_state, SCHED_IDLE);

        // in_valid while IDLE must not disturb anything
        in_valid = 1'b1; in_word = 32'hDEADBEEF; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("idle_ignores_in", busy, 0);

        load_abc();
        begin_block();
        run_block(0, 0, -1, 0, 1);

        load_abc();
        begin_block();
        run_block(1, 0, -1, 0, 1);

        load_abc();
        begin_block();
        run_block(0, 1, -1, 0, 1);

        load_abc();
        begin_block();
        run_block(0, 0, 30, 0, 1);
        load_abc();
        begin_block();
        run_block(0, 0, -1, 0, 1);

        load_abc();
        begin_block();
        run_block(0, 0, -1, 1, 1);
        load_random();
        run_block(0, 0, -1, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
